// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler tick steps a static, rotating, blinking or bouncing LED pattern.
// Define LED_ACTIVE_LOW_EN to invert the LED drive for active-low boards.
module led_pattern_gen #(
  parameter int NUM_LED   = 10,
  parameter int DIV_WIDTH = 24,
  parameter int DIV_MAX   = 12499999
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iEn,
  input  logic [1:0]         iMode,
  input  logic               iLoad,
  input  logic [NUM_LED-1:0] iPattern,
  output logic [NUM_LED-1:0] oLed,
  output logic               oTick
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam logic [DIV_WIDTH-1:0] CNT_MAX   = DIV_WIDTH'(DIV_MAX);
  localparam logic [NUM_LED-1:0]   PAT_RESET = NUM_LED'(1);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [NUM_LED-1:0]   LED_RESET = ~PAT_RESET;
`else
  localparam logic [NUM_LED-1:0]   LED_RESET = PAT_RESET;
`endif

  logic [DIV_WIDTH-1:0] rCnt, cntNext;
  logic [NUM_LED-1:0]   rPat, patNext;
  logic                 rPhase, phaseNext;
  logic                 rDir, dirNext;
  logic                 tickNext;
  logic [NUM_LED-1:0]   ledLevel, ledDrive;
  mode_t                mode;
  logic                 wrap;

  // Bounce helpers: a lit end bit forces the direction away from that end.
  logic                 oneHot;
  logic                 goDown;
  logic [NUM_LED-1:0]   bounced;

  assign mode    = mode_t'(iMode);
  assign wrap    = iEn && (rCnt == CNT_MAX);
  assign oneHot  = (rPat != '0) && ((rPat & (rPat - 1'b1)) == '0);
  assign goDown  = rPat[NUM_LED-1] | (rDir & ~rPat[0]);
  assign bounced = goDown ? (rPat >> 1) : (rPat << 1);

  always_comb begin
    cntNext   = rCnt;
    patNext   = rPat;
    phaseNext = rPhase;
    dirNext   = rDir;
    tickNext  = 1'b0;
    if (iLoad) begin
      patNext   = iPattern;
      cntNext   = '0;
      phaseNext = 1'b1;
      dirNext   = 1'b0;
    end else if (iEn) begin
      cntNext  = wrap ? '0 : rCnt + 1'b1;
      tickNext = wrap;
      if (wrap) begin
        case (mode)
          MODE_ROTATE: patNext = {rPat[NUM_LED-2:0], rPat[NUM_LED-1]};
          MODE_BLINK:  phaseNext = ~rPhase;
          MODE_BOUNCE: begin
            if (oneHot) begin
              patNext = bounced;
              dirNext = bounced[NUM_LED-1] ? 1'b1 : (bounced[0] ? 1'b0 : goDown);
            end else begin
              patNext = PAT_RESET;
              dirNext = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
    // Blink phase only has meaning in blink mode; outside it the pattern is always shown.
    if (mode != MODE_BLINK) phaseNext = 1'b1;
  end

  assign ledLevel = phaseNext ? patNext : '0;
`ifdef LED_ACTIVE_LOW_EN
  assign ledDrive = ~ledLevel;
`else
  assign ledDrive = ledLevel;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rCnt   <= '0;
      rPat   <= PAT_RESET;
      rPhase <= 1'b1;
      rDir   <= 1'b0;
      oTick  <= 1'b0;
      oLed   <= LED_RESET;
    end else begin
      rCnt   <= cntNext;
      rPat   <= patNext;
      rPhase <= phaseNext;
      rDir   <= dirNext;
      oTick  <= tickNext;
      oLed   <= ledDrive;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (NUM_LED=10, DIV_MAX=3): stimulus queues the LED value
// expected at each tick, a negedge monitor pops and compares it whenever oTick pulses.
module tb_led_pattern_gen;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rstN;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [N-1:0] pattern;
  logic [N-1:0] led;
  logic         tick;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [N-1:0] expQ[$];
  logic [N-1:0] monExp;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LED(N), .DIV_WIDTH(4), .DIV_MAX(3)) dut (
    .iClk(clk), .iRst_n(rstN), .iEn(en), .iMode(mode),
    .iLoad(load), .iPattern(pattern), .oLed(led), .oTick(tick)
  );

  function automatic logic [N-1:0] disp(input logic [N-1:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every tick pulse is one transaction.
  always @(negedge clk) begin
    if (rstN === 1'b1 && tick === 1'b1 && expQ.size() > 0) begin
      monExp = expQ.pop_front();
      $display("tick  led=%03h  expected=%03h", led, monExp);
      check("tick_led", led, monExp);
    end
  end

  // Called at negedge+1; ends at negedge+1 after the load edge.
  task automatic loadPat(input logic [N-1:0] p);
    pattern = p;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
    pattern = 10'h2AA;
    @(negedge clk);
    #1;
    $display("load  led=%03h  expected=%03h", led, disp(p));
    check("load_led", led, disp(p));
  endtask

  task automatic expectTick(input logic [N-1:0] v, input int gap);
    int n;
    n = 0;
    expQ.push_back(disp(v));
    while (expQ.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      totalCnt++;
      $display("FAIL tick_timeout: no tick within %0d clocks, expected led %03h", n, disp(v));
      expQ.delete();
    end else begin
      check("tick_gap", n, gap);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b0; pattern = '0;
    #12;
    check("reset_led", led, disp(10'h001));
    check("reset_tick", tick, 1'b0);
    @(negedge clk);
    #1;
    rstN = 1'b1;

    // Static mode: pattern holds, tick every 4 clocks.
    loadPat(10'h007);
    for (int i = 0; i < 5; i++) expectTick(10'h007, 4);

    // Rotate, then freeze with iEn low.
    mode = 2'd1;
    loadPat(10'h201);
    expectTick(10'h003, 4);
    expectTick(10'h006, 4);
    expectTick(10'h00C, 4);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("freeze_led", led, disp(10'h00C));
      check("freeze_tick", tick, 1'b0);
    end
    en = 1'b1;
    expectTick(10'h018, 4);

    // Asynchronous reset mid-count.
    rstN = 1'b0;
    #2;
    check("async_reset_led", led, disp(10'h001));
    check("async_reset_tick", tick, 1'b0);
    @(negedge clk);
    #1;
    rstN = 1'b1;

    // Bounce: walk up, reverse at top, walk down, reverse at bottom.
    mode = 2'd3;
    loadPat(10'h001);
    for (int i = 1; i < N; i++) expectTick(10'h001 << i, 4);
    for (int i = N - 2; i >= 0; i--) expectTick(10'h001 << i, 4);
    expectTick(10'h002, 4);
    loadPat(10'h005);
    expectTick(10'h001, 4);
    expectTick(10'h002, 4);

    // Blink, then a load landing on the wrap cycle.
    mode = 2'd2;
    loadPat(10'h3FF);
    expectTick(10'h000, 4);
    expectTick(10'h3FF, 4);
    expectTick(10'h000, 4);
    repeat (3) @(negedge clk);
    #1;
    loadPat(10'h155);
    check("load_on_wrap_tick", tick, 1'b0);
    expectTick(10'h000, 4);
    expectTick(10'h155, 4);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
